// File: rtl/wb_writer_if.sv
// wb_writer_if: pipeline, load-return, decode and register-file write signals of wb_writer
interface wb_writer_if #(parameter int LQ_DEPTH = 4);
  localparam int LQ_AW = $clog2(LQ_DEPTH);
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [31:0]       alu_data;
  logic              ld_issue;
  logic [4:0]        ld_issue_rd;
  logic              ld_rsp_valid;
  logic              ld_rsp_ready;
  logic [4:0]        ld_rsp_rd;
  logic [31:0]       ld_rsp_data;
  logic [4:0]        dec_rs1;
  logic [4:0]        dec_rs2;
  logic [4:0]        dec_rd;
  logic              rs_stall;
  logic              wb_stall;
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic [LQ_AW:0]    lq_count;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
           ld_rsp_valid, ld_rsp_rd, ld_rsp_data, dec_rs1, dec_rs2, dec_rd,
    input  ld_rsp_ready, rs_stall, wb_stall, wb_en, wb_rd, wb_data, lq_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
           ld_rsp_valid, ld_rsp_rd, ld_rsp_data, dec_rs1, dec_rs2, dec_rd,
    output ld_rsp_ready, rs_stall, wb_stall, wb_en, wb_rd, wb_data, lq_count
  );
endinterface

// File: rtl/wb_writer.sv
// wb_writer: merges ALU results and FIFO-buffered load returns into the register-file write port; WB_STARVE_GUARD_EN lets a full FIFO pre-empt the ALU
module wb_writer #(parameter int LQ_DEPTH = 4) (
  input  logic         clk,
  input  logic         rst,
  wb_writer_if.slave   bus
);
  localparam int LQ_AW = $clog2(LQ_DEPTH);
  localparam logic [LQ_AW:0] FULL = (LQ_AW+1)'(LQ_DEPTH);
  logic [4:0]       q_rd   [LQ_DEPTH];
  logic [31:0]      q_data [LQ_DEPTH];
  logic [LQ_AW-1:0] wp, rp;
  logic [LQ_AW:0]   cnt;
  logic [31:0]      pend;
  logic             wb_en, wb_is_ld;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             ready, push, pop, sel_alu, sel, stall;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  assign ready    = cnt != FULL;
  assign push     = bus.ld_rsp_valid && ready;
`ifdef WB_STARVE_GUARD_EN
  assign stall    = !ready && bus.ld_rsp_valid;
`else
  assign stall    = 1'b0;
`endif
  assign sel_alu  = bus.alu_valid && !stall;
  assign pop      = !sel_alu && cnt != '0;
  assign sel      = sel_alu || pop;
  assign sel_rd   = sel_alu ? bus.alu_rd : q_rd[rp];
  assign sel_data = sel_alu ? bus.alu_data : q_data[rp];
  assign bus.ld_rsp_ready = ready;
  assign bus.wb_stall     = stall;
  assign bus.lq_count     = cnt;
  assign bus.wb_en        = wb_en;
  assign bus.wb_rd        = wb_rd;
  assign bus.wb_data      = wb_data;
  assign bus.rs_stall     = pend[bus.dec_rs1] | pend[bus.dec_rs2] | pend[bus.dec_rd];
  // load-return storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wp]   <= bus.ld_rsp_rd;
      q_data[wp] <= bus.ld_rsp_data;
    end
  end
  // FIFO pointers, registered write port and pending scoreboard (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      wb_en    <= 1'b0;
      wb_is_ld <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      pend     <= '0;
    end else begin
      wp       <= wp + LQ_AW'(push);
      rp       <= rp + LQ_AW'(pop);
      cnt      <= cnt + (LQ_AW+1)'(push) - (LQ_AW+1)'(pop);
      wb_en    <= sel && sel_rd != '0;
      wb_is_ld <= pop;
      if (sel) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
      end
      if (wb_en && wb_is_ld) pend[wb_rd] <= 1'b0;
      if (bus.ld_issue && bus.ld_issue_rd != '0) pend[bus.ld_issue_rd] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed stimulus with a queue-based reference model compared every cycle
module tb_wb_writer;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wb_writer_if #(.LQ_DEPTH(D)) bus();
  wb_writer #(.LQ_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: a queue for the FIFO, a bit vector for pending loads
  typedef struct {logic [4:0] rd; logic [31:0] data;} item_t;
  item_t      q[$];
  bit [31:0]  pend_m;
  logic       m_en, m_ld;
  logic [4:0] m_rd;
  logic [31:0] m_data;
  item_t      it;
  bit         have, rdy;
  function automatic bit m_stall();
`ifdef WB_STARVE_GUARD_EN
    return q.size() == D && bus.ld_rsp_valid;
`else
    return 1'b0;
`endif
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      pend_m = '0;
      m_en = 0; m_ld = 0; m_rd = 0; m_data = 0;
    end else begin
      rdy = q.size() < D;
      have = 0;
      if (m_en && m_ld) pend_m[m_rd] = 0;
      if (bus.ld_issue && bus.ld_issue_rd != 0) pend_m[bus.ld_issue_rd] = 1;
      if (bus.alu_valid && !m_stall()) begin
        it = '{bus.alu_rd, bus.alu_data}; have = 1; m_ld = 0;
      end else if (q.size() > 0) begin
        it = q.pop_front(); have = 1; m_ld = 1;
      end
      if (bus.ld_rsp_valid && rdy) q.push_back('{bus.ld_rsp_rd, bus.ld_rsp_data});
      m_en = have && it.rd != 0;
      if (have) begin m_rd = it.rd; m_data = it.data; end
    end
  end
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("wb_en", 32'(bus.wb_en), 32'(m_en));
      if (m_en) begin
        chk("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
        chk("wb_data", bus.wb_data, m_data);
      end
      chk("lq_count", 32'(bus.lq_count), 32'(q.size()));
      chk("ld_rsp_ready", 32'(bus.ld_rsp_ready), 32'(q.size() < D));
      chk("rs_stall", 32'(bus.rs_stall), 32'(pend_m[bus.dec_rs1] | pend_m[bus.dec_rs2] | pend_m[bus.dec_rd]));
      chk("wb_stall", 32'(bus.wb_stall), 32'(m_stall()));
    end
  end
  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.ld_issue = 0; bus.ld_issue_rd = 0;
    bus.ld_rsp_valid = 0; bus.ld_rsp_rd = 0; bus.ld_rsp_data = 0;
    bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    int i, a;
    bit acc;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst wb_en", 32'(bus.wb_en), 0);
    chk("rst lq_count", 32'(bus.lq_count), 0);
    chk("rst ready", 32'(bus.ld_rsp_ready), 1);
    chk("rst rs_stall", 32'(bus.rs_stall), 0);
    chk("rst wb_stall", 32'(bus.wb_stall), 0);
    rst = 0;
    step();
    // ALU only
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h1234;
    step();
    bus.alu_valid = 0;
    chk("alu wb_en", 32'(bus.wb_en), 1);
    chk("alu wb_rd", 32'(bus.wb_rd), 5);
    chk("alu wb_data", bus.wb_data, 32'h1234);
    step();
    chk("alu idle wb_en", 32'(bus.wb_en), 0);
    // load path
    bus.ld_issue = 1; bus.ld_issue_rd = 7; bus.dec_rs1 = 7;
    step();
    bus.ld_issue = 0;
    chk("ld pend stall", 32'(bus.rs_stall), 1);
    step();
    step();
    bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 7; bus.ld_rsp_data = 32'hDEADBEEF;
    step();
    bus.ld_rsp_valid = 0;
    chk("ld count", 32'(bus.lq_count), 1);
    step();
    chk("ld wb_en", 32'(bus.wb_en), 1);
    chk("ld wb_data", bus.wb_data, 32'hDEADBEEF);
    chk("ld stall held", 32'(bus.rs_stall), 1);
    step();
    chk("ld stall clear", 32'(bus.rs_stall), 0);
    idle();
    // priority and fill
    i = 0; a = 0;
    for (int t = 0; t < 16; t++) begin
      bus.alu_valid = a < 6; bus.alu_rd = 5'(a + 1); bus.alu_data = 32'hA000 + 32'(a);
      bus.ld_rsp_valid = i < 5; bus.ld_rsp_rd = 5'(10 + i); bus.ld_rsp_data = 32'hB000 + 32'(i);
      acc = bus.ld_rsp_valid && bus.ld_rsp_ready;
      if (bus.alu_valid && !bus.wb_stall) a++;
      step();
      if (acc) i++;
      if (t == 3) begin
        chk("fill ready", 32'(bus.ld_rsp_ready), 0);
        chk("fill count", 32'(bus.lq_count), 4);
      end
    end
    idle();
    chk("drained count", 32'(bus.lq_count), 0);
    // x0 handling
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'h55;
    bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 0; bus.ld_rsp_data = 32'h66;
    bus.ld_issue = 1; bus.ld_issue_rd = 0;
    step();
    idle();
    chk("x0 no stall", 32'(bus.rs_stall), 0);
    step();
    chk("x0 pop wb_en", 32'(bus.wb_en), 0);
    step();
    chk("x0 drained", 32'(bus.lq_count), 0);
    // set/clear collision
    bus.ld_issue = 1; bus.ld_issue_rd = 9;
    step();
    idle();
    bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 9; bus.ld_rsp_data = 32'h99;
    step();
    idle();
    step();
    chk("coll wb_en", 32'(bus.wb_en), 1);
    chk("coll wb_rd", 32'(bus.wb_rd), 9);
    bus.ld_issue = 1; bus.ld_issue_rd = 9; bus.dec_rs1 = 9;
    step();
    bus.ld_issue = 0;
    chk("coll set wins", 32'(bus.rs_stall), 1);
    bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 9; bus.ld_rsp_data = 32'h199;
    step();
    bus.ld_rsp_valid = 0;
    step();
    step();
    chk("coll cleared", 32'(bus.rs_stall), 0);
    idle();
    // reset mid-operation
    bus.ld_issue = 1; bus.ld_issue_rd = 4; bus.dec_rs1 = 4;
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h1;
    for (int k = 0; k < 3; k++) begin
      bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 5'(20 + k); bus.ld_rsp_data = 32'hC00 + 32'(k);
      step();
      bus.ld_issue = 0;
    end
    bus.ld_rsp_valid = 0;
    chk("pre-rst count", 32'(bus.lq_count), 3);
    chk("pre-rst stall", 32'(bus.rs_stall), 1);
    rst = 1;
    #1;
    chk("async rst count", 32'(bus.lq_count), 0);
    chk("async rst wb_en", 32'(bus.wb_en), 0);
    chk("async rst rs_stall", 32'(bus.rs_stall), 0);
    chk("async rst ready", 32'(bus.ld_rsp_ready), 1);
    idle();
    @(negedge clk);
    rst = 0;
    step();
    step();
`ifdef WB_STARVE_GUARD_EN
    // full FIFO with a pending response pre-empts the ALU
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'hC0DE;
    for (int k = 0; k < 4; k++) begin
      bus.ld_rsp_valid = 1; bus.ld_rsp_rd = 5'(24 + k); bus.ld_rsp_data = 32'hD00 + 32'(k);
      step();
    end
    bus.ld_rsp_rd = 28; bus.ld_rsp_data = 32'hD04;
    chk("guard stall", 32'(bus.wb_stall), 1);
    step();
    bus.ld_rsp_valid = 0;
    chk("guard head wb_en", 32'(bus.wb_en), 1);
    chk("guard head rd", 32'(bus.wb_rd), 24);
    step();
    bus.alu_valid = 0;
    chk("guard alu rd", 32'(bus.wb_rd), 3);
    chk("guard alu data", bus.wb_data, 32'hC0DE);
    repeat (6) step();
`endif
    idle();
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
